// File: rtl/cpu_control_unit_if.sv
// Bus bundle between the control unit, the instruction memory and the ALU.
// Handshake: the master raises imem_req while fetching; imem_rdata is
// consumed on the first rising edge where imem_req and imem_valid are both
// high. imem_valid is ignored while imem_req is low. The ALU half is a
// plain combinational loop: alu_a/alu_b/alu_op out, alu_result back.
interface cpu_control_unit_if #(
    parameter int WIDTH    = 16,
    parameter int PC_WIDTH = 8
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_rdata;
    logic                imem_valid;
    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic [1:0]          alu_op;
    logic [WIDTH-1:0]    alu_result;

    modport master (
        output imem_req, imem_addr, alu_a, alu_b, alu_op,
        input  imem_rdata, imem_valid, alu_result
    );

    modport slave (
        input  imem_req, imem_addr, alu_a, alu_b, alu_op,
        output imem_rdata, imem_valid, alu_result
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback controller for the 16-bit core.
// Owns the PC and a 4-entry register file, fetches over the bus interface,
// drives the ALU and writes its result back.
// Optional macro CTRL_TRACE_EN adds retire_valid/retire_pc/retire_instr.
// dbg_state exposes the FSM: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE,
// 4 WRITEBACK, 5 HALT.
module cpu_control_unit #(
    parameter int WIDTH    = 16,
    parameter int PC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    cpu_control_unit_if.master   bus,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal,
    input  logic [1:0]           dbg_sel,
    output logic [WIDTH-1:0]     dbg_data,
    output logic [2:0]           dbg_state
`ifdef CTRL_TRACE_EN
    ,
    output logic                 retire_valid,
    output logic [PC_WIDTH-1:0]  retire_pc,
    output logic [15:0]          retire_instr
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;
    logic [WIDTH-1:0]    result;
    logic                wr_en;
    logic [WIDTH-1:0]    regs [4];

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [7:0] imm8;

    assign op   = ir[15:12];
    assign rd   = ir[11:10];
    assign rs1  = ir[9:8];
    assign rs2  = ir[7:6];
    assign imm8 = ir[7:0];

    assign bus.imem_addr = pc;
    assign dbg_data      = regs[dbg_sel];
    assign dbg_state     = state;

    // Main FSM: sequencing, register file, PC and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            ir           <= '0;
            result       <= '0;
            wr_en        <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_op   <= 2'b00;
            bus.imem_req <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_FETCH;
                        bus.imem_req <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_valid) begin
                        ir           <= bus.imem_rdata;
                        state        <= S_DECODE;
                        bus.imem_req <= 1'b0;
                    end
                end
                S_DECODE: begin
                    case (op)
                        4'h0, 4'h1, 4'h2, 4'h3: begin
                            bus.alu_a  <= regs[rs1];
                            bus.alu_b  <= regs[rs2];
                            bus.alu_op <= op[1:0];
                            wr_en      <= 1'b1;
                            state      <= S_EXECUTE;
                        end
                        4'h4: begin
                            bus.alu_a  <= {{(WIDTH-8){1'b0}}, imm8};
                            bus.alu_b  <= '0;
                            bus.alu_op <= 2'b00;
                            wr_en      <= 1'b1;
                            state      <= S_EXECUTE;
                        end
                        4'h5: begin
                            state  <= S_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                        4'h6: begin
                            wr_en <= 1'b0;
                            state <= S_WRITEBACK;
                        end
                        default: begin
                            wr_en   <= 1'b0;
                            illegal <= 1'b1;
                            state   <= S_WRITEBACK;
                        end
                    endcase
                end
                S_EXECUTE: begin
                    result <= bus.alu_result;
                    state  <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (wr_en) regs[rd] <= result;
                    pc           <= pc + PC_WIDTH'(1);
                    state        <= S_FETCH;
                    bus.imem_req <= 1'b1;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CTRL_TRACE_EN
    // Retire trace: pulse during WRITEBACK, or during the DECODE that halts.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_valid <= 1'b0;
            retire_pc    <= '0;
            retire_instr <= '0;
        end else begin
            retire_valid <= 1'b0;
            if (state == S_FETCH && bus.imem_valid &&
                bus.imem_rdata[15:12] == 4'h5) begin
                retire_valid <= 1'b1;
                retire_pc    <= pc;
                retire_instr <= bus.imem_rdata;
            end else if (state == S_EXECUTE ||
                         (state == S_DECODE && op >= 4'h6)) begin
                retire_valid <= 1'b1;
                retire_pc    <= pc;
                retire_instr <= ir;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: instruction memory and ALU models, a small
// reference interpreter that fills the scoreboard queues, and directed plus
// randomised programs. A second instance with PC_WIDTH=2 covers PC wrap.
module tb_cpu_control_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0 (PC_WIDTH = 8) ----------------
    cpu_control_unit_if #(.WIDTH(16), .PC_WIDTH(8)) bus ();
    logic        busy, halted, illegal;
    logic [1:0]  dbg_sel = 2'd0;
    logic [15:0] dbg_data;
    logic [2:0]  dbg_state;
    logic [15:0] mem [256];

    cpu_control_unit #(.WIDTH(16), .PC_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data),
        .dbg_state (dbg_state)
    );

    assign bus.imem_rdata = mem[bus.imem_addr];
    initial bus.imem_valid = 1'b0;

    // reference ALU
    always_comb begin
        bus.alu_result = 16'h0;
        case (bus.alu_op)
            2'b00: bus.alu_result = bus.alu_a + bus.alu_b;
            2'b01: bus.alu_result = bus.alu_a - bus.alu_b;
            2'b10: bus.alu_result = bus.alu_a & bus.alu_b;
            2'b11: bus.alu_result = bus.alu_a | bus.alu_b;
            default: bus.alu_result = 16'h0;
        endcase
    end

    // ---------------- DUT 1 (PC_WIDTH = 2, NOP memory) ----------------
    cpu_control_unit_if #(.WIDTH(16), .PC_WIDTH(2)) bus2 ();
    logic        busy2, halted2, illegal2;
    logic [15:0] dbg_data2;
    logic [2:0]  dbg_state2;

    cpu_control_unit #(.WIDTH(16), .PC_WIDTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .bus       (bus2),
        .busy      (busy2),
        .halted    (halted2),
        .illegal   (illegal2),
        .dbg_sel   (2'd0),
        .dbg_data  (dbg_data2),
        .dbg_state (dbg_state2)
    );

    assign bus2.imem_rdata = 16'h6000;
    assign bus2.alu_result = bus2.alu_a + bus2.alu_b;
    initial bus2.imem_valid = 1'b0;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];   // expected fetch addresses, in order
    logic [15:0] reg_q [$];   // expected final register values r0..r3
    logic [7:0]  m_pc;
    logic        m_ill;
    int          m_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference interpreter: runs mem from PC 0 until HALT and pushes
    // the fetch order and final register file into the queues.
    task automatic model_run(input int wait_n);
        logic [15:0] r [4];
        logic [15:0] ins;
        logic [15:0] a, b;
        logic [3:0]  op;
        bit          done;
        exp_q.delete();
        reg_q.delete();
        for (int i = 0; i < 4; i++) r[i] = 16'h0;
        m_pc = 8'h0; m_ill = 1'b0; m_cycles = 0; done = 0;
        for (int s = 0; s < 200 && !done; s++) begin
            exp_q.push_back(16'(m_pc));
            ins = mem[m_pc];
            op  = ins[15:12];
            m_cycles += wait_n + 1;
            if (op <= 4'h3) begin
                a = r[ins[9:8]];
                b = r[ins[7:6]];
                case (op[1:0])
                    2'b00: r[ins[11:10]] = a + b;
                    2'b01: r[ins[11:10]] = a - b;
                    2'b10: r[ins[11:10]] = a & b;
                    default: r[ins[11:10]] = a | b;
                endcase
                m_cycles += 3; m_pc++;
            end else if (op == 4'h4) begin
                r[ins[11:10]] = {8'h0, ins[7:0]};
                m_cycles += 3; m_pc++;
            end else if (op == 4'h5) begin
                m_cycles += 1; done = 1;
            end else if (op == 4'h6) begin
                m_cycles += 2; m_pc++;
            end else begin
                m_ill = 1'b1;
                m_cycles += 2; m_pc++;
            end
        end
        for (int i = 0; i < 4; i++) reg_q.push_back(r[i]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.imem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_prog(input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2, input logic [15:0] p3);
        for (int i = 0; i < 256; i++) mem[i] = 16'h5000;
        mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3;
    endtask

    task automatic read_reg(input int idx, output logic [15:0] val);
        dbg_sel = 2'(idx);
        #1;
        val = dbg_data;
    endtask

    // Runs the loaded program on DUT 0 with wait_n wait states per fetch.
    // abort_pc >= 0 pulses rst during EXECUTE of the instruction at that PC.
    task automatic run_dut(input string name, input int wait_n, input int abort_pc);
        int cnt = 0;
        int cyc = 0;
        bit done = 0;
        logic [15:0] v;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            start = (i == 0);
            if (halted) begin
                done = 1;
            end else begin
                if (abort_pc >= 0 && dbg_state == 3'd3 && bus.imem_addr == 8'(abort_pc)) begin
                    rst = 1'b1;
                    bus.imem_valid = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                if (busy) cyc++;
                if (bus.imem_req) begin
                    if (cnt > 0) check({name, "_wait_in_fetch"}, 32'(dbg_state), 32'd1);
                    if (cnt == wait_n) begin
                        if (exp_q.size() == 0) begin
                            check({name, "_fetch_extra"}, 32'(bus.imem_addr), 32'hFFFF);
                        end else begin
                            check({name, "_fetch_addr"}, 32'(bus.imem_addr), 32'(exp_q.pop_front()));
                        end
                        bus.imem_valid = 1'b1;
                        cnt = 0;
                    end else begin
                        bus.imem_valid = 1'b0;
                        cnt++;
                    end
                end else begin
                    bus.imem_valid = 1'($urandom_range(0, 1));
                    cnt = 0;
                end
            end
        end
        start = 1'b0;
        bus.imem_valid = 1'b0;
        check({name, "_halt_reached"}, 32'(done), 32'd1);
        check({name, "_cycles"}, 32'(cyc), 32'(m_cycles));
        check({name, "_fetch_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_halted"}, 32'(halted), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_req"}, 32'(bus.imem_req), 32'd0);
        check({name, "_illegal"}, 32'(illegal), 32'(m_ill));
        check({name, "_pc"}, 32'(bus.imem_addr), 32'(m_pc));
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            check({name, "_reg"}, 32'(v), 32'(reg_q.pop_front()));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] v;
        int fetched;
        load_prog(16'h4405, 16'h4803, 16'h1D80, 16'h5000);
        do_reset();

        // reset state
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        check("rst_flags", 32'({busy, halted, illegal}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // LDI/LDI/SUB/HALT, zero wait: r1=5 r2=3 r3=2, 14 busy cycles, PC 3
        model_run(0);
        run_dut("sub", 0, -1);
        check("sub_cycles_abs", 32'(m_cycles), 32'd14);

        // wrap: r3 = 3 - 5
        load_prog(16'h4405, 16'h4803, 16'h1E40, 16'h5000);
        do_reset();
        model_run(0);
        run_dut("wrap", 0, -1);
        read_reg(3, v);
        check("wrap_r3_abs", 32'(v), 32'hFFFE);

        // illegal op then HALT
        load_prog(16'hF000, 16'h5000, 16'h5000, 16'h5000);
        do_reset();
        model_run(0);
        run_dut("illegal", 0, -1);

        // five wait states on every fetch
        load_prog(16'h4405, 16'h4803, 16'h1D80, 16'h5000);
        do_reset();
        model_run(5);
        run_dut("wait5", 5, -1);

        // rst during EXECUTE of SUB, then re-run from PC 0
        do_reset();
        model_run(0);
        run_dut("abort", 0, 2);
        check("abort_req", 32'(bus.imem_req), 32'd0);
        check("abort_addr", 32'(bus.imem_addr), 32'd0);
        check("abort_alu", 32'({bus.alu_a, bus.alu_b}), 32'd0);
        check("abort_alu_op", 32'(bus.alu_op), 32'd0);
        check("abort_flags", 32'({busy, halted, illegal}), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            check("abort_reg", 32'(v), 32'd0);
        end
        model_run(0);
        run_dut("rerun", 0, -1);

        // randomised programs with random wait states
        for (int t = 0; t < 3; t++) begin
            int w;
            for (int i = 0; i < 256; i++) mem[i] = 16'h5000;
            for (int i = 0; i < 4; i++)
                mem[i] = {4'h4, 2'(i), 2'b00, 8'($urandom_range(0, 255))};
            for (int i = 4; i < 12; i++)
                mem[i] = {4'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 6'h0};
            w = $urandom_range(0, 2);
            do_reset();
            model_run(w);
            run_dut("rand", w, -1);
        end

        // PC_WIDTH=2 wrap on NOPs, start pulses while busy are ignored
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(16'(i % 4));
        fetched = 0;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            start2 = (i == 0) || (i == 6) || (i == 11);
            if (bus2.imem_req) begin
                check("pcwrap_addr", 32'(bus2.imem_addr), 32'(exp_q.pop_front()));
                bus2.imem_valid = 1'b1;
                fetched++;
            end else begin
                bus2.imem_valid = 1'b0;
            end
        end
        start2 = 1'b0;
        bus2.imem_valid = 1'b0;
        check("pcwrap_fetches", 32'(fetched), 32'd7);
        check("pcwrap_busy", 32'(busy2), 32'd1);
        check("pcwrap_halted", 32'(halted2), 32'd0);
        check("pcwrap_illegal", 32'(illegal2), 32'd0);

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
